// File: rtl/clyde_msk_round_ctrl.sv
// rtl/clyde_msk_round_ctrl.sv - round sequencer for the masked Clyde-128 core
module clyde_msk_round_ctrl #(
  parameter int SB_LAT = 3,
  parameter int NSTEPS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       inverse,
  output logic       busy,
  output logic       done,
  input  logic       rnd_valid,
  output logic       rnd_ready,
  output logic       sb_en,
  output logic [1:0] state_sel,
  output logic       lb_en,
  output logic       tk_add,
  output logic [3:0] round_idx,
  output logic [2:0] step_idx
);

  localparam int CW = (SB_LAT > 1) ? $clog2(SB_LAT) : 1;
  localparam logic [CW-1:0] WAIT_INIT  = CW'(SB_LAT - 1);
  localparam logic [3:0]    LAST_ROUND = 4'(2 * NSTEPS - 1);
  localparam logic [2:0]    LAST_STEP  = 3'(NSTEPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TK,
    S_SB_REQ,
    S_SB_WAIT,
    S_LB,
    S_DONE
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic          inv;
  // Index to present on the next LB / TK entry; round_idx/step_idx are
  // loaded from these on entry so they hold steady outside LB/TK.
  logic [3:0]    round_nxt;
  logic [2:0]    step_nxt;

  // State register, direction latch, index counters and S-box wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      inv       <= 1'b0;
      round_nxt <= 4'd0;
      step_nxt  <= 3'd0;
      round_idx <= 4'd0;
      step_idx  <= 3'd0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && start) begin
        inv       <= inverse;
        round_nxt <= inverse ? LAST_ROUND : 4'd0;
        step_nxt  <= inverse ? LAST_STEP : 3'd0;
      end
      if (next_state == S_TK) begin
        step_idx <= step_nxt;
        step_nxt <= inv ? step_nxt - 3'd1 : step_nxt + 3'd1;
      end
      if (next_state == S_LB) begin
        round_idx <= round_nxt;
        round_nxt <= inv ? round_nxt - 4'd1 : round_nxt + 4'd1;
      end
      if (state == S_SB_REQ) begin
        wait_cnt <= WAIT_INIT;
      end else if (state == S_SB_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - CW'(1);
      end
    end
  end

  // Next-state: encrypt runs SB->LB per round, inverse runs LB->SB per round
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_LOAD;
      S_LOAD:    next_state = S_TK;
      S_TK: begin
        if (inv ? (step_idx == 3'd0) : (step_idx == LAST_STEP)) next_state = S_DONE;
        else if (inv) next_state = S_LB;
        else next_state = S_SB_REQ;
      end
      S_SB_REQ:  if (rnd_valid) next_state = S_SB_WAIT;
      S_SB_WAIT: begin
        if (wait_cnt == '0) begin
          if (inv && !round_idx[0]) next_state = S_TK;
          else if (inv) next_state = S_LB;
          else next_state = S_LB;
        end
      end
      S_LB: begin
        if (inv) next_state = S_SB_REQ;
        else if (round_idx[0]) next_state = S_TK;
        else next_state = S_SB_REQ;
      end
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Moore output decode; sb_en is the only output that follows an input
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    rnd_ready = (state == S_SB_REQ);
    sb_en     = (state == S_SB_REQ) && rnd_valid;
    lb_en     = (state == S_LB);
    tk_add    = (state == S_TK);
    state_sel = 2'd0;
    case (state)
      S_LOAD:    state_sel = 2'd1;
      S_TK:      state_sel = 2'd3;
      S_LB:      state_sel = 2'd3;
      S_SB_WAIT: if (wait_cnt == '0) state_sel = 2'd2;
      default:   state_sel = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_clyde_msk_round_ctrl.sv
// tb/tb_clyde_msk_round_ctrl.sv - self-checking bench for clyde_msk_round_ctrl
module tb_clyde_msk_round_ctrl;

  localparam int L = 3;
  localparam int N = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, inverse = 1'b0, rnd_valid = 1'b1;
  logic       busy, done, rnd_ready, sb_en, lb_en, tk_add;
  logic [1:0] state_sel;
  logic [3:0] round_idx;
  logic [2:0] step_idx;

  logic       start2 = 1'b0, inverse2 = 1'b0, rnd_valid2 = 1'b1;
  logic       busy2, done2, rnd_ready2, sb_en2, lb_en2, tk_add2;
  logic [1:0] state_sel2;
  logic [3:0] round_idx2;
  logic [2:0] step_idx2;

  clyde_msk_round_ctrl #(.SB_LAT(L), .NSTEPS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse), .busy(busy), .done(done),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .sb_en(sb_en), .state_sel(state_sel),
    .lb_en(lb_en), .tk_add(tk_add), .round_idx(round_idx), .step_idx(step_idx));

  clyde_msk_round_ctrl #(.SB_LAT(1), .NSTEPS(2)) dut_small (
    .clk(clk), .rst(rst), .start(start2), .inverse(inverse2), .busy(busy2), .done(done2),
    .rnd_valid(rnd_valid2), .rnd_ready(rnd_ready2), .sb_en(sb_en2), .state_sel(state_sel2),
    .lb_en(lb_en2), .tk_add(tk_add2), .round_idx(round_idx2), .step_idx(step_idx2));

  always #5 clk = ~clk;

  typedef struct {
    logic inv;
    int   stall_hs;
    int   stall_len;
    int   exp_done;
  } vec_t;

  vec_t vecs[3];
  int checks = 0;
  int errors = 0;

  int tk_cyc[$], tk_step[$], lb_cyc[$], lb_rnd[$], sb_cyc[$], cap_cyc[$];
  int done_cyc, busy_bad, stall_bad, stall_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {busy, done, rnd_ready, sb_en, state_sel, lb_en, tk_add, round_idx, step_idx};
  endfunction

  task automatic run_op(input vec_t v);
    int cyc;
    int stalled;
    tk_cyc.delete(); tk_step.delete(); lb_cyc.delete(); lb_rnd.delete();
    sb_cyc.delete(); cap_cyc.delete();
    done_cyc = -1; busy_bad = 0; stall_bad = 0; stall_seen = 0; stalled = 0;
    @(posedge clk); #1;
    start = 1'b1; inverse = v.inv; rnd_valid = 1'b1;
    cyc = 0;
    while (done_cyc < 0 && cyc < 200) begin
      @(negedge clk);
      if (cyc > 0 && !busy) busy_bad++;
      if (cyc == 0 && busy) busy_bad++;
      if (sb_en) sb_cyc.push_back(cyc);
      if (state_sel == 2'd2) cap_cyc.push_back(cyc);
      if (tk_add) begin tk_cyc.push_back(cyc); tk_step.push_back(int'(step_idx)); end
      if (lb_en) begin lb_cyc.push_back(cyc); lb_rnd.push_back(int'(round_idx)); end
      if (rnd_ready && !rnd_valid) begin
        stall_seen++;
        if (sb_en || state_sel != 2'd0) stall_bad++;
      end
      if (done) done_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
      start = (cyc == 5 || cyc == v.exp_done) ? 1'b1 : 1'b0;
      if (cyc > 1) inverse = ~inverse;
      rnd_valid = 1'b1;
      if (rnd_ready && sb_cyc.size() == v.stall_hs && stalled < v.stall_len) begin
        rnd_valid = 1'b0;
        stalled++;
      end
    end
    start = 1'b0;
    inverse = 1'b0;
    rnd_valid = 1'b1;
    @(negedge clk);
    check("idle_after_done", busy, 1'b0);
    @(negedge clk);
    check("done_start_ignored", busy, 1'b0);
  endtask

  task automatic check_run(input vec_t v);
    int n;
    int exp_c;
    check("done_cycle", done_cyc, v.exp_done);
    check("busy_window", busy_bad, 0);
    check("tk_count", tk_cyc.size(), N + 1);
    n = (tk_cyc.size() < N + 1) ? tk_cyc.size() : N + 1;
    for (int i = 0; i < n; i++) begin
      exp_c = 2 + i * (2 * (L + 2) + 1);
      if (v.stall_hs >= 0 && 2 * i > v.stall_hs) exp_c += v.stall_len;
      check("tk_cycle", tk_cyc[i], exp_c);
      check("tk_step", tk_step[i], v.inv ? N - i : i);
    end
    check("lb_count", lb_cyc.size(), 2 * N);
    check("sb_count", sb_cyc.size(), 2 * N);
    check("cap_count", cap_cyc.size(), 2 * N);
    n = 2 * N;
    if (lb_cyc.size() < n) n = lb_cyc.size();
    if (sb_cyc.size() < n) n = sb_cyc.size();
    if (cap_cyc.size() < n) n = cap_cyc.size();
    for (int j = 0; j < n; j++) begin
      check("lb_round", lb_rnd[j], v.inv ? 2 * N - 1 - j : j);
      check("cap_latency", cap_cyc[j], sb_cyc[j] + L);
      if (v.inv) check("lb_before_sb", sb_cyc[j], lb_cyc[j] + 1);
      else check("lb_after_cap", lb_cyc[j], cap_cyc[j] + 1);
    end
    if (v.stall_hs >= 0) begin
      check("stall_cycles", stall_seen, v.stall_len);
      check("stall_outputs", stall_bad, 0);
    end
  endtask

  initial begin
    int cnt;
    int caps_after;
    int cyc;
    int last_sb;
    int d2;
    int hs2;
    int tk2;

    vecs[0] = '{inv: 1'b0, stall_hs: -1, stall_len: 0, exp_done: 69};
    vecs[1] = '{inv: 1'b1, stall_hs: -1, stall_len: 0, exp_done: 69};
    vecs[2] = '{inv: 1'b0, stall_hs: 4,  stall_len: 5, exp_done: 74};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 15'd0);
    check("reset_outputs_small", {busy2, done2, rnd_ready2, sb_en2, state_sel2, lb_en2,
                                  tk_add2, round_idx2, step_idx2}, 15'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      run_op(vecs[k]);
      check_run(vecs[k]);
    end

    // Reset during the SB_WAIT that follows the 8th handshake (round 7)
    @(posedge clk); #1;
    start = 1'b1; inverse = 1'b0; rnd_valid = 1'b1;
    cnt = 0; cyc = 0;
    while (cnt < 8 && cyc < 200) begin
      @(negedge clk);
      if (sb_en) cnt++;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check("reach_round7", cnt, 8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midop_reset_outputs", outs(), 15'd0);
    caps_after = 0;
    repeat (10) begin
      @(negedge clk);
      if (state_sel == 2'd2) caps_after++;
    end
    check("no_capture_after_reset", caps_after, 0);
    run_op(vecs[0]);
    check_run(vecs[0]);

    // Small configuration: SB_LAT=1, NSTEPS=2
    @(posedge clk); #1;
    start2 = 1'b1;
    cyc = 0; d2 = -1; hs2 = 0; tk2 = 0; last_sb = -10;
    while (d2 < 0 && cyc < 100) begin
      @(negedge clk);
      if (state_sel2 == 2'd2) check("small_cap_latency", cyc, last_sb + 1);
      if (sb_en2) begin hs2++; last_sb = cyc; end
      if (tk_add2) tk2++;
      if (done2) d2 = cyc;
      @(posedge clk); #1;
      start2 = 1'b0;
      cyc++;
    end
    check("small_done_cycle", d2, 17);
    check("small_handshakes", hs2, 4);
    check("small_tk_count", tk2, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
